// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage.
//   - opcode constants (7-bit major opcodes)
//   - op_class_e : coarse instruction class handed to execute
//   - alu_op_e   : ALU operation selector
//   - uop_t      : registered micro-op produced by decode
//   - alu_from_funct3 : funct3 (+ alternate bit) to ALU op for OP / OP_IMM
package decode_pkg;

  localparam int unsigned UopXlen = 32;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  typedef enum logic [3:0] {
    ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBranch, ClsLoad,
    ClsStore, ClsOpImm, ClsOp, ClsFence, ClsSystem, ClsIllegal
  } op_class_e;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor,
    AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_op_e;

  typedef struct packed {
    logic [UopXlen-1:0] pc;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [UopXlen-1:0] imm;
    alu_op_e            alu_op;
    op_class_e          op_class;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               rd_we;
    logic               illegal;
  } uop_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101; ignored otherwise.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I instruction cracker.
//   instr_i : raw 32-bit instruction word
//   pc_i    : PC of instr_i, copied into the micro-op
//   uop_o   : decoded micro-op (register indices are the raw instruction fields)
// Illegal encodings produce op_class=ClsIllegal, imm=0, and all control flags clear.
module decode_logic
  import decode_pkg::*;
(
  input  logic [31:0]         instr_i,
  input  logic [UopXlen-1:0]  pc_i,
  output uop_t                uop_o
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [UopXlen-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  always_comb begin
    logic ill;
    ill          = 1'b0;
    uop_o        = '0;
    uop_o.pc     = pc_i;
    uop_o.rd     = instr_i[11:7];
    uop_o.rs1    = instr_i[19:15];
    uop_o.rs2    = instr_i[24:20];
    uop_o.funct3 = funct3;
    uop_o.alu_op = AluAdd;
    uop_o.op_class = ClsIllegal;

    if (instr_i[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opcode)
        OpcLui: begin
          uop_o.op_class = ClsLui;
          uop_o.imm      = imm_u;
          uop_o.alu_op   = AluPassB;
          uop_o.rd_we    = 1'b1;
        end
        OpcAuipc: begin
          uop_o.op_class = ClsAuipc;
          uop_o.imm      = imm_u;
          uop_o.rd_we    = 1'b1;
        end
        OpcJal: begin
          uop_o.op_class = ClsJal;
          uop_o.imm      = imm_j;
          uop_o.rd_we    = 1'b1;
        end
        OpcJalr: begin
          uop_o.op_class = ClsJalr;
          uop_o.imm      = imm_i;
          uop_o.uses_rs1 = 1'b1;
          uop_o.rd_we    = 1'b1;
        end
        OpcBranch: begin
          uop_o.op_class = ClsBranch;
          uop_o.imm      = imm_b;
          uop_o.uses_rs1 = 1'b1;
          uop_o.uses_rs2 = 1'b1;
          // BEQ/BNE compare by subtraction, the rest by signed/unsigned less-than.
          case (funct3[2:1])
            2'b10:   uop_o.alu_op = AluSlt;
            2'b11:   uop_o.alu_op = AluSltu;
            default: uop_o.alu_op = AluSub;
          endcase
        end
        OpcLoad: begin
          uop_o.op_class = ClsLoad;
          uop_o.imm      = imm_i;
          uop_o.uses_rs1 = 1'b1;
          uop_o.rd_we    = 1'b1;
        end
        OpcStore: begin
          uop_o.op_class = ClsStore;
          uop_o.imm      = imm_s;
          uop_o.uses_rs1 = 1'b1;
          uop_o.uses_rs2 = 1'b1;
        end
        OpcOpImm: begin
          uop_o.op_class = ClsOpImm;
          uop_o.imm      = imm_i;
          uop_o.uses_rs1 = 1'b1;
          uop_o.rd_we    = 1'b1;
          // ADDI has no subtract form, so only the right shift honours funct7[5].
          uop_o.alu_op   = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
          if (funct3 == 3'b001 && funct7 != 7'h00) ill = 1'b1;
          if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20) ill = 1'b1;
        end
        OpcOp: begin
          uop_o.op_class = ClsOp;
          uop_o.uses_rs1 = 1'b1;
          uop_o.uses_rs2 = 1'b1;
          uop_o.rd_we    = 1'b1;
          uop_o.alu_op   = alu_from_funct3(funct3, funct7[5]);
          if (!(funct7 == 7'h00 ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
            ill = 1'b1;
          end
        end
        OpcFence: begin
          uop_o.op_class = ClsFence;
          uop_o.imm      = imm_i;
        end
        OpcSystem: begin
          uop_o.op_class = ClsSystem;
          uop_o.imm      = imm_i;
          // Only CSR forms write rd; ECALL/EBREAK do not.
          uop_o.rd_we    = (funct3 != 3'b000);
        end
        default: ill = 1'b1;
      endcase
    end

    if (uop_o.rd == 5'd0) uop_o.rd_we = 1'b0;

    if (ill) begin
      uop_o.op_class = ClsIllegal;
      uop_o.imm      = '0;
      uop_o.alu_op   = AluAdd;
      uop_o.uses_rs1 = 1'b0;
      uop_o.uses_rs2 = 1'b0;
      uop_o.rd_we    = 1'b0;
      uop_o.illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage with a 2-entry skid buffer.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   flush_i                : drop every held and incoming instruction
//   valid_i/ready_o        : fetch-side handshake (ready_o is registered)
//   instruction_i, pc_i    : instruction beat from fetch
//   valid_o/ready_i        : execute-side handshake
//   uop_o                  : registered micro-op, stable while valid_o && !ready_i
// Instructions are decoded before being stored, so the skid entry already holds a uop.
module decode
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output uop_t            uop_o
);

  if (XLEN != UopXlen) begin : g_xlen_check
    $error("decode: only XLEN=32 is supported");
  end

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q;
  uop_t   out_q, skid_q, dec_uop;
  logic   accept, out_fire;

  decode_logic u_decode_logic (
    .instr_i (instruction_i),
    .pc_i    (pc_i),
    .uop_o   (dec_uop)
  );

  assign accept   = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;
  assign uop_o    = out_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else if (flush_i) begin
      // Flush wins over any simultaneous accept or output transfer.
      state_q <= StEmpty;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            out_q   <= dec_uop;
            valid_o <= 1'b1;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && !out_fire) begin
            skid_q  <= dec_uop;
            ready_o <= 1'b0;
            state_q <= StTwo;
          end else if (out_fire && !accept) begin
            valid_o <= 1'b0;
            state_q <= StEmpty;
          end else if (accept && out_fire) begin
            out_q   <= dec_uop;
          end
        end
        StTwo: begin
          // ready_o is low here, so no new beat can arrive alongside the drain.
          if (out_fire) begin
            out_q   <= skid_q;
            ready_o <= 1'b1;
            state_q <= StOne;
          end
        end
        default: begin
          state_q <= StEmpty;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode.sv
module tb_decode;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  uop_t        uop;

  int n_checks = 0;
  int n_errors = 0;

  decode #(.XLEN(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .valid_i       (valid_in),
    .ready_o       (ready_out),
    .instruction_i (instr),
    .pc_i          (pc),
    .valid_o       (valid_out),
    .ready_i       (ready_in),
    .uop_o         (uop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_uop(input string nm, input uop_t act, input uop_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    alu_op_e     alu;
    op_class_e   cls;
    logic        u1;
    logic        u2;
    logic        we;
    logic        ill;
  } vec_t;

  localparam int NVec = 14;
  vec_t vecs[NVec];

  function automatic uop_t exp_uop(input vec_t v, input logic [31:0] p);
    uop_t e;
    e          = '0;
    e.pc       = p;
    e.rd       = v.instr[11:7];
    e.rs1      = v.instr[19:15];
    e.rs2      = v.instr[24:20];
    e.funct3   = v.instr[14:12];
    e.imm      = v.imm;
    e.alu_op   = v.alu;
    e.op_class = v.cls;
    e.uses_rs1 = v.u1;
    e.uses_rs2 = v.u2;
    e.rd_we    = v.we;
    e.illegal  = v.ill;
    return e;
  endfunction

  initial begin
    logic [31:0] expq[3];
    int          idx;
    logic        took;
    logic [31:0] p;

    vecs[0]  = '{32'hFFF10093, 32'hFFFFFFFF, AluAdd,   ClsOpImm,   1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h123452B7, 32'h12345000, AluPassB, ClsLui,     1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h402081B3, 32'h00000000, AluSub,   ClsOp,      1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{32'h802081B3, 32'h00000000, AluAdd,   ClsIllegal, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'h00000000, 32'h00000000, AluAdd,   ClsIllegal, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h4032D213, 32'h00000403, AluSra,   ClsOpImm,   1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'h40329213, 32'h00000000, AluAdd,   ClsIllegal, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'hFE20AE23, 32'hFFFFFFFC, AluAdd,   ClsStore,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'hFE208CE3, 32'hFFFFFFF8, AluSub,   ClsBranch,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h010000EF, 32'h00000010, AluAdd,   ClsJal,     1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h00208033, 32'h00000000, AluAdd,   ClsOp,      1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'hFFFFF397, 32'hFFFFF000, AluAdd,   ClsAuipc,   1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{32'h0080A303, 32'h00000008, AluAdd,   ClsLoad,    1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{32'h004100E7, 32'h00000004, AluAdd,   ClsJalr,    1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_bit("reset_valid", valid_out, 1'b0);
    chk_bit("reset_ready", ready_out, 1'b1);
    chk_uop("reset_uop", uop, '0);

    // Single-beat decode table, execute always ready
    ready_in = 1'b1;
    for (int i = 0; i < NVec; i++) begin
      p        = 32'h1000 + 32'(i * 4);
      valid_in = 1'b1;
      instr    = vecs[i].instr;
      pc       = p;
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      chk_bit($sformatf("vec%0d_valid", i), valid_out, 1'b1);
      chk_uop($sformatf("vec%0d_uop", i), uop, exp_uop(vecs[i], p));
      @(negedge clk);
      chk_bit($sformatf("vec%0d_drain", i), valid_out, 1'b0);
    end

    // Backpressure: A and B fill the skid, C waits in fetch
    expq[0] = 32'h2000; expq[1] = 32'h2004; expq[2] = 32'h2008;
    ready_in = 1'b0;
    valid_in = 1'b1; instr = 32'hFFF10093; pc = expq[0];
    @(negedge clk);
    instr = 32'h123452B7; pc = expq[1];
    @(negedge clk);
    instr = 32'h004100E7; pc = expq[2];
    chk_bit("skid_full_ready", ready_out, 1'b0);
    chk_bit("skid_full_valid", valid_out, 1'b1);
    chk_word("skid_head_pc", uop.pc, expq[0]);
    @(negedge clk);
    chk_bit("skid_hold_ready", ready_out, 1'b0);
    chk_uop("skid_hold_uop", uop, exp_uop(vecs[0], expq[0]));
    ready_in = 1'b1;
    idx = 0;
    took = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (took) valid_in = 1'b0;
      if (valid_out && ready_in) begin
        if (idx < 3) chk_word($sformatf("order_%0d", idx), uop.pc, expq[idx]);
        idx++;
      end
      if (valid_in && ready_out) took = 1'b1;
      @(negedge clk);
    end
    chk_word("order_count", 32'(idx), 32'd3);

    // Flush while full, with a beat offered and execute ready
    ready_in = 1'b0;
    valid_in = 1'b1; instr = 32'hFFF10093; pc = 32'h3000;
    @(negedge clk);
    pc = 32'h3004;
    @(negedge clk);
    chk_bit("flush_pre_ready", ready_out, 1'b0);
    flush = 1'b1; ready_in = 1'b1; pc = 32'h3008;
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b0;
    chk_bit("flush_valid", valid_out, 1'b0);
    chk_bit("flush_ready", ready_out, 1'b1);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      chk_bit($sformatf("flush_no_ghost_%0d", cyc), valid_out, 1'b0);
    end

    // Asynchronous reset while one entry is held
    ready_in = 1'b0;
    valid_in = 1'b1; instr = 32'h123452B7; pc = 32'h4000;
    @(negedge clk);
    valid_in = 1'b0;
    chk_bit("arst_pre_valid", valid_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_bit("arst_valid", valid_out, 1'b0);
    chk_bit("arst_ready", ready_out, 1'b1);
    chk_uop("arst_uop", uop, '0);
    @(negedge clk);
    rst = 1'b0;
    ready_in = 1'b1;
    valid_in = 1'b1; instr = 32'hFFF10093; pc = 32'h5000;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    chk_bit("post_rst_valid", valid_out, 1'b1);
    chk_uop("post_rst_uop", uop, exp_uop(vecs[0], 32'h5000));
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
